// File: rtl/ser_rx_sync_ctrl.sv
// rtl/ser_rx_sync_ctrl.sv - SERDES receive link-sync controller: comma lock/verify/resync FSM.
// Optional lock-loss statistics counter enabled by defining SER_RX_SYNC_STATS_EN.
module ser_rx_sync_ctrl #(
  parameter int LOCK_CNT      = 4,
  parameter int ERR_LIMIT     = 3,
  parameter int COMMA_TIMEOUT = 1024,
  parameter int RST_CYCLES    = 4
) (
  input  logic        ser_rx_clk_i,
  input  logic        ser_rx_rst_n,
  input  logic [15:0] ser_r_i,
  input  logic        ser_rklsb_i,
  input  logic        ser_rkmsb_i,
  input  logic        force_resync_i,
  output logic        link_up_o,
  output logic        align_rst_n_o,
  output logic [1:0]  sync_state_o,
  output logic        lock_lost_o,
  output logic [15:0] lock_loss_cnt_o
);

  localparam logic [1:0] ST_HUNT   = 2'd0;
  localparam logic [1:0] ST_VERIFY = 2'd1;
  localparam logic [1:0] ST_LOCKED = 2'd2;
  localparam logic [1:0] ST_RESYNC = 2'd3;

  localparam int TW = $clog2(COMMA_TIMEOUT);
  localparam int GW = $clog2(LOCK_CNT + 1);
  localparam int EW = $clog2(ERR_LIMIT + 1);
  localparam int RW = $clog2(RST_CYCLES + 1);

  logic [1:0]    state, state_d;
  logic [TW-1:0] timer, timer_d;
  logic [GW-1:0] good_cnt, good_d;
  logic [EW-1:0] err_cnt, err_d;
  logic [RW-1:0] rst_left, rst_left_d;
  logic          lost_d;
  logic          is_good, is_mis, tmo;

  assign is_good = ser_rkmsb_i & ser_rklsb_i & (ser_r_i == 16'h3C3C);
  assign is_mis  = (~ser_rkmsb_i & ser_rklsb_i & (ser_r_i[7:0] == 8'h3C)) |
                   (ser_rkmsb_i & ~ser_rklsb_i & (ser_r_i[15:8] == 8'h3C));
  assign tmo     = ~is_good & (timer == TW'(COMMA_TIMEOUT - 1));

  always_comb begin
    state_d    = state;
    good_d     = good_cnt;
    err_d      = err_cnt;
    rst_left_d = rst_left;
    lost_d     = 1'b0;
    timer_d    = (is_good || tmo) ? '0 : timer + TW'(1);
    if (force_resync_i) begin
      state_d = ST_RESYNC;
      lost_d  = (state == ST_LOCKED);
    end else begin
      case (state)
        ST_HUNT: begin
          if (is_good) begin
            good_d  = GW'(1);
            state_d = (LOCK_CNT == 1) ? ST_LOCKED : ST_VERIFY;
          end
        end
        ST_VERIFY: begin
          if (is_good) begin
            good_d = good_cnt + GW'(1);
            if (good_cnt == GW'(LOCK_CNT - 1)) state_d = ST_LOCKED;
          end else if (is_mis) begin
            state_d = ST_RESYNC;
          end else if (tmo) begin
            state_d = ST_HUNT;
            good_d  = '0;
          end
        end
        ST_LOCKED: begin
          if (is_good) begin
            err_d = '0;
          end else if (is_mis || tmo) begin
            if (err_cnt == EW'(ERR_LIMIT - 1)) begin
              state_d = ST_RESYNC;
              lost_d  = 1'b1;
            end else begin
              err_d = err_cnt + EW'(1);
            end
          end
        end
        default: begin
          if (rst_left == '0) state_d = ST_HUNT;
          else                rst_left_d = rst_left - RW'(1);
        end
      endcase
    end
    // A forced request while already in RESYNC reloads the hold count like a fresh entry.
    if (state_d == ST_RESYNC && (state != ST_RESYNC || force_resync_i))
      rst_left_d = RW'(RST_CYCLES - 1);
    if (state_d == ST_RESYNC) begin
      good_d = '0;
      err_d  = '0;
    end
    if (state_d == ST_RESYNC || state == ST_RESYNC) timer_d = '0;
  end

  always_ff @(posedge ser_rx_clk_i or negedge ser_rx_rst_n) begin
    if (!ser_rx_rst_n) begin
      state         <= ST_HUNT;
      timer         <= '0;
      good_cnt      <= '0;
      err_cnt       <= '0;
      rst_left      <= '0;
      link_up_o     <= 1'b0;
      align_rst_n_o <= 1'b1;
      lock_lost_o   <= 1'b0;
    end else begin
      state         <= state_d;
      timer         <= timer_d;
      good_cnt      <= good_d;
      err_cnt       <= err_d;
      rst_left      <= rst_left_d;
      link_up_o     <= (state_d == ST_LOCKED);
      align_rst_n_o <= (state_d != ST_RESYNC);
      lock_lost_o   <= lost_d;
    end
  end

  assign sync_state_o = state;

`ifdef SER_RX_SYNC_STATS_EN
  logic [15:0] loss_cnt;

  always_ff @(posedge ser_rx_clk_i or negedge ser_rx_rst_n) begin
    if (!ser_rx_rst_n)                        loss_cnt <= '0;
    else if (lost_d && loss_cnt != 16'hFFFF)  loss_cnt <= loss_cnt + 16'd1;
  end

  assign lock_loss_cnt_o = loss_cnt;
`else
  assign lock_loss_cnt_o = 16'h0000;
`endif

endmodule

// File: tb/tb_ser_rx_sync_ctrl.sv
// tb/tb_ser_rx_sync_ctrl.sv - self-checking bench for ser_rx_sync_ctrl with a behavioural link model.
module tb_ser_rx_sync_ctrl;

  localparam int LOCK_CNT      = 4;
  localparam int ERR_LIMIT     = 3;
  localparam int COMMA_TIMEOUT = 1024;
  localparam int RST_CYCLES    = 4;
  localparam int S_HUNT = 0, S_VERIFY = 1, S_LOCKED = 2, S_RESYNC = 3;
`ifdef SER_RX_SYNC_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] ser_r_i = '0;
  logic        ser_rklsb_i = 1'b0;
  logic        ser_rkmsb_i = 1'b0;
  logic        force_resync_i = 1'b0;
  logic        link_up_o, align_rst_n_o, lock_lost_o;
  logic [1:0]  sync_state_o;
  logic [15:0] lock_loss_cnt_o;

  int n_checks = 0;
  int n_pass = 0;

  int m_state, m_good, m_err, m_timer, m_hold, m_cnt;
  bit m_lost;

  always #5 clk = ~clk;

  ser_rx_sync_ctrl dut (
    .ser_rx_clk_i    (clk),
    .ser_rx_rst_n    (rst_n),
    .ser_r_i         (ser_r_i),
    .ser_rklsb_i     (ser_rklsb_i),
    .ser_rkmsb_i     (ser_rkmsb_i),
    .force_resync_i  (force_resync_i),
    .link_up_o       (link_up_o),
    .align_rst_n_o   (align_rst_n_o),
    .sync_state_o    (sync_state_o),
    .lock_lost_o     (lock_lost_o),
    .lock_loss_cnt_o (lock_loss_cnt_o)
  );

  task automatic model_reset();
    m_state = S_HUNT; m_good = 0; m_err = 0; m_timer = 0; m_hold = 0; m_cnt = 0; m_lost = 0;
  endtask

  task automatic go_resync();
    m_state = S_RESYNC; m_hold = RST_CYCLES; m_good = 0; m_err = 0; m_timer = 0;
  endtask

  task automatic model_step(input logic [15:0] d, input logic [1:0] k, input logic f);
    bit good, mis, tmo;
    good = (k == 2'b11) && (d == 16'h3C3C);
    mis  = ((k == 2'b01) && (d[7:0] == 8'h3C)) || ((k == 2'b10) && (d[15:8] == 8'h3C));
    tmo  = !good && (m_timer == COMMA_TIMEOUT - 1);
    m_lost = 0;
    if (m_state != S_RESYNC) m_timer = (good || tmo) ? 0 : m_timer + 1;
    if (f) begin
      m_lost = (m_state == S_LOCKED);
      go_resync();
    end else if (m_state == S_HUNT) begin
      if (good) begin
        m_good = 1;
        m_state = (m_good >= LOCK_CNT) ? S_LOCKED : S_VERIFY;
      end
    end else if (m_state == S_VERIFY) begin
      if (good) begin
        m_good++;
        if (m_good >= LOCK_CNT) m_state = S_LOCKED;
      end else if (mis) go_resync();
      else if (tmo) begin
        m_state = S_HUNT; m_good = 0;
      end
    end else if (m_state == S_LOCKED) begin
      if (good) m_err = 0;
      else if (mis || tmo) begin
        m_err++;
        if (m_err >= ERR_LIMIT) begin
          m_lost = 1;
          go_resync();
        end
      end
    end else begin
      m_hold--;
      if (m_hold == 0) m_state = S_HUNT;
    end
    if (STATS && m_lost && m_cnt < 65535) m_cnt++;
  endtask

  task automatic step(input logic [15:0] d, input logic [1:0] k, input logic f);
    ser_r_i = d; {ser_rkmsb_i, ser_rklsb_i} = k; force_resync_i = f;
    @(posedge clk); #1;
    model_step(d, k, f);
  endtask

  task automatic good_w();    step(16'h3C3C, 2'b11, 1'b0); endtask
  task automatic mis_w();     step(16'h003C, 2'b01, 1'b0); endtask
  task automatic neutral_w(); step(16'h0000, 2'b00, 1'b0); endtask

  task automatic do_reset();
    rst_n = 1'b0; ser_r_i = '0; ser_rklsb_i = 0; ser_rkmsb_i = 0; force_resync_i = 0;
    model_reset();
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    repeat (LOCK_CNT) good_w();
    #3 rst_n = 1'b0;
    #1;
    n_checks++; if (sync_state_o !== 2'd0) $display("FAIL reset_state: got %0d want 0", sync_state_o); else n_pass++;
    n_checks++; if (link_up_o !== 1'b0) $display("FAIL reset_link_up: got %b want 0", link_up_o); else n_pass++;
    n_checks++; if (align_rst_n_o !== 1'b1) $display("FAIL reset_align_rst_n: got %b want 1", align_rst_n_o); else n_pass++;
    n_checks++; if (lock_lost_o !== 1'b0) $display("FAIL reset_lock_lost: got %b want 0", lock_lost_o); else n_pass++;
    n_checks++; if (lock_loss_cnt_o !== 16'h0) $display("FAIL reset_loss_cnt: got %0d want 0", lock_loss_cnt_o); else n_pass++;
    model_reset();
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_lock();
    do_reset();
    good_w();
    n_checks++; if (sync_state_o !== 2'd1) $display("FAIL lock_first_good: got %0d want 1", sync_state_o); else n_pass++;
    good_w(); good_w();
    n_checks++; if (sync_state_o !== 2'd1 || link_up_o !== 1'b0) $display("FAIL lock_third_good: state %0d link %b want 1/0", sync_state_o, link_up_o); else n_pass++;
    good_w();
    n_checks++; if (sync_state_o !== 2'd2 || link_up_o !== 1'b1) $display("FAIL lock_fourth_good: state %0d link %b want 2/1", sync_state_o, link_up_o); else n_pass++;
  endtask

  task automatic test_mis_loss();
    int lost_total, low;
    do_reset();
    repeat (LOCK_CNT) good_w();
    mis_w(); neutral_w(); mis_w(); neutral_w(); mis_w();
    n_checks++; if (sync_state_o !== 2'd3 || link_up_o !== 1'b0) $display("FAIL loss_enter_resync: state %0d link %b want 3/0", sync_state_o, link_up_o); else n_pass++;
    lost_total = int'(lock_lost_o);
    low = int'(!align_rst_n_o);
    for (int i = 0; i < 8; i++) begin
      neutral_w();
      lost_total += int'(lock_lost_o);
      low += int'(!align_rst_n_o);
    end
    n_checks++; if (lost_total != 1) $display("FAIL loss_pulse_count: got %0d want 1", lost_total); else n_pass++;
    n_checks++; if (low != RST_CYCLES) $display("FAIL loss_align_low_cycles: got %0d want %0d", low, RST_CYCLES); else n_pass++;
    n_checks++; if (sync_state_o !== 2'd0 || align_rst_n_o !== 1'b1) $display("FAIL loss_back_to_hunt: state %0d align %b want 0/1", sync_state_o, align_rst_n_o); else n_pass++;
  endtask

  task automatic test_err_clear();
    do_reset();
    repeat (LOCK_CNT) good_w();
    mis_w(); mis_w(); good_w(); mis_w(); mis_w();
    n_checks++; if (sync_state_o !== 2'd2 || link_up_o !== 1'b1) $display("FAIL err_clear_stay_locked: state %0d link %b want 2/1", sync_state_o, link_up_o); else n_pass++;
  endtask

  task automatic test_timeout();
    bit link_seen;
    do_reset();
    good_w();
    link_seen = 0;
    repeat (COMMA_TIMEOUT - 1) begin
      neutral_w();
      link_seen |= link_up_o;
    end
    n_checks++; if (sync_state_o !== 2'd1) $display("FAIL timeout_early: got %0d want 1", sync_state_o); else n_pass++;
    neutral_w();
    link_seen |= link_up_o;
    n_checks++; if (sync_state_o !== 2'd0) $display("FAIL timeout_to_hunt: got %0d want 0", sync_state_o); else n_pass++;
    n_checks++; if (link_seen !== 1'b0) $display("FAIL timeout_link_up: got %b want 0", link_seen); else n_pass++;
  endtask

  task automatic test_force();
    int low;
    do_reset();
    good_w(); good_w();
    step(16'h3C3C, 2'b11, 1'b1);
    n_checks++; if (sync_state_o !== 2'd3 || align_rst_n_o !== 1'b0) $display("FAIL force_priority: state %0d align %b want 3/0", sync_state_o, align_rst_n_o); else n_pass++;
    low = 1;
    neutral_w(); low += int'(!align_rst_n_o);
    step(16'h0000, 2'b00, 1'b1); low += int'(!align_rst_n_o);
    for (int i = 0; i < 8; i++) begin
      neutral_w();
      low += int'(!align_rst_n_o);
    end
    n_checks++; if (low != RST_CYCLES + 2) $display("FAIL force_restart_low_cycles: got %0d want %0d", low, RST_CYCLES + 2); else n_pass++;
    repeat (LOCK_CNT - 1) good_w();
    n_checks++; if (sync_state_o !== 2'd1) $display("FAIL force_good_cnt_cleared: got %0d want 1", sync_state_o); else n_pass++;
    good_w();
    step(16'h0000, 2'b00, 1'b1);
    n_checks++; if (lock_lost_o !== 1'b1 || link_up_o !== 1'b0) $display("FAIL force_from_locked: lost %b link %b want 1/0", lock_lost_o, link_up_o); else n_pass++;
  endtask

  task automatic test_stats();
    logic [15:0] exp;
    do_reset();
    repeat (2) begin
      repeat (LOCK_CNT) good_w();
      step(16'h0000, 2'b00, 1'b1);
      repeat (RST_CYCLES + 1) neutral_w();
    end
    exp = STATS ? 16'd2 : 16'd0;
    n_checks++; if (lock_loss_cnt_o !== exp) $display("FAIL stats_loss_count: got %0d want %0d", lock_loss_cnt_o, exp); else n_pass++;
  endtask

  task automatic test_random();
    logic [15:0] d;
    logic [1:0]  k;
    logic        f;
    int r;
    do_reset();
    for (int i = 0; i < 2000; i++) begin
      r = $urandom_range(0, 9);
      if (r <= 4) begin d = 16'h3C3C; k = 2'b11; end
      else if (r <= 6) begin
        d = 16'($urandom);
        if ($urandom_range(0, 1) == 1) begin d[7:0] = 8'h3C; k = 2'b01; end
        else begin d[15:8] = 8'h3C; k = 2'b10; end
      end else if (r <= 8) begin d = 16'($urandom); k = 2'($urandom); end
      else begin d = 16'h0000; k = 2'b00; end
      f = ($urandom_range(0, 63) == 0);
      step(d, k, f);
      n_checks++; if (sync_state_o !== 2'(m_state)) $display("FAIL rnd_state cyc %0d: got %0d want %0d", i, sync_state_o, m_state); else n_pass++;
      n_checks++; if (link_up_o !== (m_state == S_LOCKED)) $display("FAIL rnd_link_up cyc %0d: got %b want %b", i, link_up_o, m_state == S_LOCKED); else n_pass++;
      n_checks++; if (align_rst_n_o !== (m_state != S_RESYNC)) $display("FAIL rnd_align cyc %0d: got %b want %b", i, align_rst_n_o, m_state != S_RESYNC); else n_pass++;
      n_checks++; if (lock_lost_o !== m_lost) $display("FAIL rnd_lock_lost cyc %0d: got %b want %b", i, lock_lost_o, m_lost); else n_pass++;
      n_checks++; if (lock_loss_cnt_o !== 16'(m_cnt)) $display("FAIL rnd_loss_cnt cyc %0d: got %0d want %0d", i, lock_loss_cnt_o, m_cnt); else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_lock();
    test_mis_loss();
    test_err_clear();
    test_timeout();
    test_force();
    test_stats();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
